// File: rtl/n64_pkg.sv
// n64_pkg: command codes, receiver FSM states and the address CRC polynomial.
package n64_pkg;

   localparam logic [7:0] CMD_INFO   = 8'h00;
   localparam logic [7:0] CMD_STATUS = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] CMD_WRITE  = 8'h03;
   localparam logic [7:0] CMD_RESET  = 8'hFF;

   // x^5 + x^4 + x^2 + 1 with the x^5 term implicit
   localparam logic [4:0] CRC_POLY = 5'h15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEAS_LOW,
      S_MEAS_HIGH,
      S_EVAL,
      S_WAIT_IDLE
   } state_t;

   function automatic logic is_short_cmd(input logic [7:0] c);
      return c == CMD_INFO || c == CMD_STATUS || c == CMD_RESET;
   endfunction

endpackage

// File: rtl/n64_addr_crc5.sv
// n64_addr_crc5: 5-bit address CRC over 11 address bits, MSB-first, augmented by 5 zero bits.
module n64_addr_crc5
   import n64_pkg::*;
(
   input  logic [10:0] data_i,
   output logic [4:0]  crc_o
);

   logic [15:0] msg;

   always_comb begin
      msg   = {data_i, 5'b0};
      crc_o = '0;
      for (int i = 15; i >= 0; i--)
         crc_o = {crc_o[3:0], msg[i]} ^ (crc_o[4] ? CRC_POLY : 5'd0);
   end

endmodule

// File: rtl/n64_cmd_rx.sv
// n64_cmd_rx: decodes console-to-controller N64 command frames from the sampled bus line,
// streaming WRITE payload bytes and flagging malformed frames.
module n64_cmd_rx
   import n64_pkg::*;
#(
   parameter  int CLKS_PER_US   = 4,
   parameter  int IDLE_US       = 3,
   parameter  int MAX_LOW_US    = 5,
   parameter  int PAYLOAD_BYTES = 32,
   localparam int IDX_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1
) (
   input  logic             sample_clk,
   input  logic             reset_n,
   input  logic             data_rx,
   input  logic             tx_active,
   output logic             cmd_valid,
   output logic [7:0]       cmd,
   output logic [15:0]      addr,
   output logic             addr_crc_ok,
   output logic             wr_byte_valid,
   output logic [7:0]       wr_byte,
   output logic [IDX_W-1:0] wr_byte_idx,
   output logic             frame_err
);

   localparam int CNT_W = $clog2((MAX_LOW_US + IDLE_US + 2) * CLKS_PER_US + 2);
   localparam logic [CNT_W-1:0] LOW_MAX   = CNT_W'(MAX_LOW_US * CLKS_PER_US);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_US * CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] BIT_T     = CNT_W'(2 * CLKS_PER_US);
   localparam logic [8:0]       WR_BITS   = 9'(24 + 8 * PAYLOAD_BYTES);
   localparam logic [IDX_W:0]   PAY_N     = (IDX_W + 1)'(PAYLOAD_BYTES);

   state_t           state_q;
   logic [1:0]       sync_q;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [8:0]       bit_cnt_q;
   logic             bit_q;
   logic [23:0]      sh_q;
   logic [7:0]       byte_q;
   logic [IDX_W:0]   pay_cnt_q;
   logic [7:0]       cmd_q;
   logic [15:0]      addr_q;
   logic             crc_ok_q;
   logic             cmd_valid_q;
   logic             frame_err_q;
   logic             wr_valid_q;
   logic [7:0]       wr_byte_q;
   logic [IDX_W-1:0] wr_idx_q;

   logic       line, fall, rise;
   logic [8:0] bit_cnt_d;
   logic [7:0] byte_d;
   logic [4:0] crc;
   logic       byte_done, short_ok, read_ok, write_ok, frame_ok;

   n64_addr_crc5 u_crc (
      .data_i(sh_q[15:5]),
      .crc_o (crc)
   );

   assign line      = sync_q[1];
   assign fall      = prev_q & ~line;
   assign rise      = ~prev_q & line;
   assign bit_cnt_d = (bit_cnt_q == 9'h1FF) ? bit_cnt_q : bit_cnt_q + 1'b1;
   assign byte_d    = {byte_q[6:0], bit_q};
   // sh_q freezes after 24 bits, so its top byte is the command once the address is in
   assign byte_done = sh_q[23:16] == CMD_WRITE && bit_cnt_q >= 9'd31 && bit_cnt_q[2:0] == 3'd7
                      && bit_cnt_q != 9'h1FF && pay_cnt_q < PAY_N;
   assign short_ok  = bit_cnt_q == 9'd8 && is_short_cmd(sh_q[7:0]);
   assign read_ok   = bit_cnt_q == 9'd24 && sh_q[23:16] == CMD_READ;
   assign write_ok  = bit_cnt_q == WR_BITS && sh_q[23:16] == CMD_WRITE;
   // bit_q still holds the last decoded bit, which is the stop bit
   assign frame_ok  = bit_q & (short_ok | read_ok | write_ok);

   always_ff @(posedge sample_clk or negedge reset_n)
      if (!reset_n) begin
         state_q     <= S_IDLE;
         sync_q      <= 2'b11;
         prev_q      <= 1'b1;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         bit_q       <= 1'b0;
         sh_q        <= '0;
         byte_q      <= '0;
         pay_cnt_q   <= '0;
         cmd_q       <= 8'hFE;
         addr_q      <= '0;
         crc_ok_q    <= 1'b1;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_byte_q   <= '0;
         wr_idx_q    <= '0;
      end else begin
         sync_q      <= {sync_q[0], data_rx};
         prev_q      <= line;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         wr_valid_q  <= 1'b0;
         if (tx_active) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            pay_cnt_q <= '0;
         end else
            case (state_q)
               S_IDLE:
                  if (fall) begin
                     state_q   <= S_MEAS_LOW;
                     cnt_q     <= '0;
                     bit_cnt_q <= '0;
                     pay_cnt_q <= '0;
                     sh_q      <= '0;
                  end
               S_MEAS_LOW:
                  if (rise) begin
                     state_q <= S_MEAS_HIGH;
                     cnt_q   <= '0;
                     bit_q   <= cnt_q < BIT_T;
                  end else if (cnt_q > LOW_MAX) begin
                     state_q     <= S_WAIT_IDLE;
                     cnt_q       <= '0;
                     frame_err_q <= 1'b1;
                  end else
                     cnt_q <= cnt_q + 1'b1;
               S_MEAS_HIGH:
                  if (fall) begin
                     state_q   <= S_MEAS_LOW;
                     cnt_q     <= '0;
                     bit_cnt_q <= bit_cnt_d;
                     byte_q    <= byte_d;
                     if (bit_cnt_q < 9'd24)
                        sh_q <= {sh_q[22:0], bit_q};
                     if (byte_done) begin
                        wr_valid_q <= 1'b1;
                        wr_byte_q  <= byte_d;
                        wr_idx_q   <= pay_cnt_q[IDX_W-1:0];
                        pay_cnt_q  <= pay_cnt_q + 1'b1;
                     end
                  end else if (cnt_q >= IDLE_LAST)
                     state_q <= S_EVAL;
                  else
                     cnt_q <= cnt_q + 1'b1;
               S_EVAL: begin
                  state_q <= S_IDLE;
                  if (frame_ok) begin
                     cmd_valid_q <= 1'b1;
                     cmd_q       <= short_ok ? sh_q[7:0] : sh_q[23:16];
                     addr_q      <= short_ok ? 16'h0000 : sh_q[15:0];
                     crc_ok_q    <= short_ok ? 1'b1 : crc == sh_q[4:0];
                  end else
                     frame_err_q <= 1'b1;
               end
               S_WAIT_IDLE:
                  if (!line)
                     cnt_q <= '0;
                  else if (cnt_q >= IDLE_LAST)
                     state_q <= S_IDLE;
                  else
                     cnt_q <= cnt_q + 1'b1;
               default: state_q <= S_IDLE;
            endcase
      end

   assign cmd_valid     = cmd_valid_q;
   assign cmd           = cmd_q;
   assign addr          = addr_q;
   assign addr_crc_ok   = crc_ok_q;
   assign wr_byte_valid = wr_valid_q;
   assign wr_byte       = wr_byte_q;
   assign wr_byte_idx   = wr_idx_q;
   assign frame_err     = frame_err_q;

endmodule
